// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: md_op encodings, default latencies and FSM state type for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return op >= MD_MULT && op <= MD_DIVU;
    endfunction
endpackage

// File: rtl/mdu_hilo.sv
// mdu_hilo: HI/LO register pair with fixed-latency mult/div, mt writes and mf reads; flush-safe via req.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        hilo_busy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;
    logic          busy, start_now, is_div;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   abs_a, abs_b, div_b, ud_b, uq, ur, q_s, r_s, q_u, r_u, nxt_hi, nxt_lo;
    logic          nxt_wr;

    assign busy      = state == BUSY;
    assign start_now = is_arith(md_op) && !busy && !req;
    assign hilo_busy = busy || start_now;
    assign is_div    = md_op == MD_DIV || md_op == MD_DIVU;
    assign md_out    = md_op == MD_MFHI ? hi : md_op == MD_MFLO ? lo : '0;

    // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000, rem 0).
    always_comb begin
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u = {32'b0, rs_val} * {32'b0, rt_val};
        abs_a  = rs_val[31] ? -rs_val : rs_val;
        abs_b  = rt_val[31] ? -rt_val : rt_val;
        div_b  = rt_val == '0 ? 32'd1 : abs_b;
        ud_b   = rt_val == '0 ? 32'd1 : rt_val;
        uq     = abs_a / div_b;
        ur     = abs_a % div_b;
        q_s    = (rs_val[31] ^ rt_val[31]) ? -uq : uq;
        r_s    = rs_val[31] ? -ur : ur;
        q_u    = rs_val / ud_b;
        r_u    = rs_val % ud_b;
        nxt_hi = md_op == MD_MULT ? prod_s[63:32] : md_op == MD_MULTU ? prod_u[63:32] :
                 md_op == MD_DIV ? r_s : r_u;
        nxt_lo = md_op == MD_MULT ? prod_s[31:0] : md_op == MD_MULTU ? prod_u[31:0] :
                 md_op == MD_DIV ? q_s : q_u;
        nxt_wr = !is_div || rt_val != '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (state == IDLE) begin
            if (start_now) begin
                pend_hi <= nxt_hi;
                pend_lo <= nxt_lo;
                pend_wr <= nxt_wr;
                cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state   <= BUSY;
            end else if (!req && md_op == MD_MTHI) begin
                hi <= rs_val;
            end else if (!req && md_op == MD_MTLO) begin
                lo <= rs_val;
            end
        end else if (cnt == CW'(1)) begin
            if (pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            cnt   <= '0;
            state <= IDLE;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed plan plus randomized ops against an arithmetic reference model of HI/LO.
module tb_mdu_hilo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        hilo_busy;
    logic [31:0] md_out, hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
        .hilo_busy(hilo_busy), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from the arithmetic definitions, using 64-bit integers.
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output bit wr);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        wr = 1'b1;
        if (op == 4'd1) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (op == 4'd2) begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (op == 4'd3 || op == 4'd4) begin
            if (b == 0) wr = 1'b0;
            else begin
                if (op == 4'd4) begin
                    sa = longint'({32'b0, a});
                    sb = longint'({32'b0, b});
                end
                q = sa / sb;
                r = sa % sb;
                h = r[31:0];
                l = q[31:0];
            end
        end
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
        logic [31:0] eh, el;
        bit wr, st;
        int n;
        md_op = op;
        rs_val = a;
        rt_val = b;
        req = rq;
        #1;
        st = (op >= 4'd1 && op <= 4'd4) && !rq;
        chk("busy_at_issue", {31'b0, hilo_busy}, {31'b0, st});
        chk("md_out", md_out, op == 4'd7 ? m_hi : op == 4'd8 ? m_lo : 32'd0);
        ref_op(op, a, b, eh, el, wr);
        tick();
        md_op = 4'd0;
        req = 1'b0;
        if (!rq && op == 4'd5) m_hi = a;
        if (!rq && op == 4'd6) m_lo = a;
        if (st) begin
            n = (op >= 4'd3) ? 10 : 5;
            for (int i = 0; i < n; i++) begin
                #1;
                chk("busy_cycle", {31'b0, hilo_busy}, 32'd1);
                tick();
            end
            if (wr) begin
                m_hi = eh;
                m_lo = el;
            end
        end
        #1;
        chk("busy_done", {31'b0, hilo_busy}, 32'd0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        md_op = 4'd0;
        req = 1'b0;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] a, b;
        tick();
        do_reset();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'b0, hilo_busy}, 32'd0);

        run_op(4'd1, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        chk("t1_hi", hi, 32'hFFFFFFFF);
        chk("t1_lo", lo, 32'hFFFFFFFA);

        run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("t2_hi", hi, 32'hFFFFFFFE);
        chk("t2_lo", lo, 32'h00000001);
        run_op(4'd7, 32'd0, 32'd0, 1'b0);
        md_op = 4'd7;
        #1;
        chk("t2_mfhi", md_out, 32'hFFFFFFFE);

        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("t3_lo", lo, 32'hFFFFFFFD);
        chk("t3_hi", hi, 32'hFFFFFFFF);
        run_op(4'd4, 32'd7, 32'd0, 1'b0);
        chk("t3_dz_lo", lo, 32'hFFFFFFFD);
        chk("t3_dz_hi", hi, 32'hFFFFFFFF);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);

        do_reset();
        run_op(4'd5, 32'h12345678, 32'd0, 1'b1);
        chk("t4_mthi_req", hi, 32'd0);
        run_op(4'd5, 32'h12345678, 32'd0, 1'b0);
        chk("t4_mthi", hi, 32'h12345678);
        run_op(4'd1, 32'd9, 32'd9, 1'b1);
        chk("t4_mult_req_lo", lo, 32'd0);

        md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        md_op = 4'd0;
        tick();
        tick();
        md_op = 4'd1; req = 1'b1;
        tick();
        md_op = 4'd6; req = 1'b0; rs_val = 32'hDEADBEEF;
        #1;
        chk("t5_busy_mtlo", {31'b0, hilo_busy}, 32'd1);
        tick();
        md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd3;
        tick();
        md_op = 4'd0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_lo", lo, 32'd14);
        chk("t5_hi", hi, 32'd2);
        chk("t5_idle", {31'b0, hilo_busy}, 32'd0);
        m_hi = 32'd2;
        m_lo = 32'd14;

        md_op = 4'd1; rs_val = 32'd1000; rt_val = 32'd1000;
        tick();
        md_op = 4'd0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", {31'b0, hilo_busy}, 32'd0);
        chk("t6_hi", hi, 32'd0);
        chk("t6_lo", lo, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_late_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
